deserializer: RTL and testbench
===============================

Name: deserializer

Overview:
- Serial-to-parallel receive stage. Sits directly downstream of the serializer.
- Samples the serializer's data_out bit stream, qualified by its busy line, and reassembles DATA_WIDTH-bit words MSB-first.
- Presents each word to the next stage through a one-entry valid/ready holding register.
- Reports framing errors and overruns through sticky flags.

Parameters:
- DATA_WIDTH, 8, word width in bits; also the number of serial bits per frame, excluding parity.

Ports:
- clock  in  1  single rising-edge clock, shared with the serializer.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial data bit; connects to serializer data_out.
- serial_valid  in  1  bit qualifier; connects to serializer busy. One bit is consumed per clock while high.
- data_out  out  DATA_WIDTH  assembled word.
- data_valid  out  1  data_out holds an unconsumed word.
- data_ready  in  1  consumer accepts data_out on a clock edge where data_valid & data_ready.
- frame_err  out  1  sticky: a frame ended early.
- overrun  out  1  sticky: a completed word was dropped.
- flags_clr  in  1  synchronous clear of frame_err, overrun and parity_err.
- parity_err  out  1  parity mismatch on the current data_out word (see Optional Feature).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, bit_cnt=0, shift register=0.
  - data_out=0, data_valid=0, frame_err=0, overrun=0, parity_err=0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - serial_valid=1: shift in serial_in, bit_cnt=1, go to SHIFT.
  - DATA_WIDTH=1 special case: the word completes in the same cycle and the FSM stays in IDLE.
- SHIFT, serial_valid=1:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in}; bit_cnt++.
  - When bit_cnt reaches FRAME_LEN (DATA_WIDTH, or DATA_WIDTH+1 with parity): the word is complete, bit_cnt=0, go to IDLE.
  - Back-to-back frames: if serial_valid stays high, the next cycle starts a new frame from IDLE with no lost bit.
- SHIFT, serial_valid=0 before completion:
  - Partial word discarded, bit_cnt=0, go to IDLE, frame_err<=1.
- Latency: the final bit is sampled at edge N; data_out/data_valid update at that same edge and are visible the cycle after the last bit.
- Holding register on word completion:
  - data_valid=0: load the word, data_valid<=1.
  - data_valid=1 and data_ready=1 in the same cycle: the old word is consumed and the new word loaded; data_valid stays 1.
  - data_valid=1 and data_ready=0: the new word is dropped, data_out unchanged, overrun<=1.
- Handshake without completion: data_valid & data_ready clears data_valid. data_out holds its value while data_valid=1 and is never modified while data_ready=0.
- data_ready is ignored while data_valid=0.
- Sticky flags:
  - Cleared only by reset or flags_clr.
  - If flags_clr and a new error event coincide, the set wins.
- Widths: bit_cnt is $clog2(FRAME_LEN+1) bits; no other arithmetic.
- Reset mid-frame: everything returns to reset values immediately, with no partial-word output.

Optional Feature:
- Macro: DESERIALIZER_PARITY_CHECK_EN.
- Defined:
  - FRAME_LEN = DATA_WIDTH+1; the trailing bit is the even-parity bit over the data bits.
  - The word is still delivered.
  - parity_err is loaded with the mismatch result whenever a word is loaded into the holding register; it is valid alongside data_valid.
  - A parity bit missing because of a gap is a frame_err.
- Undefined:
  - FRAME_LEN = DATA_WIDTH.
  - parity_err is tied to 0; the port remains so the port list is stable.

Decomposition:
- Package deserializer_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - the FRAME_LEN derivation;
  - the bit_cnt width function.
- Sub-module deser_hold_reg: the one-entry valid/ready holding register with overrun detection (inputs: load, word, perr, ready; outputs: data_out, data_valid, parity_err, drop). Top level holds the FSM, shift register and flags.

Test Plan:
- Single word: serial_valid=1 for 8 cycles with bits 1,0,0,1,1,1,1,0 and data_ready=1 → data_out=8'b1001_1110 with data_valid high for exactly 1 cycle; frame_err=0, overrun=0.
- Back-to-back: 16 contiguous valid bits carrying 8'h9E then 8'h3C, data_ready=0 until the first word appears, then 1 → 8'h9E then 8'h3C delivered in order; no overrun.
- Overrun: two words with data_ready held 0 → data_out stays 8'h9E, overrun=1. Pulsing flags_clr then gives overrun=0.
- Frame gap: 5 valid bits, serial_valid=0, then a full 8'hA5 frame → frame_err=1, the first data_valid carries 8'hA5, and no partial word appears.
- Async reset: assert reset=0 mid-frame (after 4 bits) between clock edges → all outputs 0 immediately. After release, a full 8'h9E frame decodes correctly.
- Parity (macro defined): send 8'h9E + parity 1 → parity_err=0. Send 8'h9E + parity 0 → data_out=8'h9E, parity_err=1.

Source files
------------

// File: rtl/deserializer_pkg.sv
// rtl/deserializer_pkg.sv - shared FSM encoding and frame sizing helpers for the deserializer
// Frame length depends on DESERIALIZER_PARITY_CHECK_EN.
package deserializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Serial bits per frame: data bits plus an optional trailing even-parity bit.
    function automatic int frame_len(input int data_width);
`ifdef DESERIALIZER_PARITY_CHECK_EN
        return data_width + 1;
`else
        return data_width;
`endif
    endfunction

    function automatic int cnt_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

endpackage

// File: rtl/deser_hold_reg.sv
// rtl/deser_hold_reg.sv - one-entry valid/ready holding register with overrun drop detection
module deser_hold_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] word,
    input  logic                  perr,
    input  logic                  ready,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_err,
    output logic                  drop
);

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  perr_q;
    logic                  accept;

    // A new word fits if the slot is empty or the current word leaves this cycle.
    assign accept = load && (!valid_q || ready);
    assign drop   = load && valid_q && !ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            if (accept) begin
                data_q  <= word;
                valid_q <= 1'b1;
                perr_q  <= perr;
            end else begin
                if (valid_q && ready) begin
                    valid_q <= 1'b0;
                end
                if (clr) begin
                    perr_q <= 1'b0;
                end
            end
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - MSB-first serial-to-parallel receiver with sticky framing/overrun flags
// Optional parity checking is enabled with DESERIALIZER_PARITY_CHECK_EN.
module deserializer
    import deserializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  serial_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  flags_clr,
    output logic                  parity_err
);

    localparam int FRAME_LEN = frame_len(DATA_WIDTH);
    localparam int CW        = cnt_width(FRAME_LEN);

    state_e                state_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic                  frame_err_q;
    logic                  overrun_q;

    logic                  last_bit;
    logic                  shift_en;
    logic                  gap;
    logic                  drop;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_perr;

    generate
        if (DATA_WIDTH == 1) begin : g_shift_one
            assign shift_d = serial_in;
        end else begin : g_shift_wide
            assign shift_d = {shift_q[DATA_WIDTH-2:0], serial_in};
        end
    endgenerate

    assign last_bit = serial_valid && (cnt_q == CW'(FRAME_LEN - 1));
    // Only data bits enter the shift register; a trailing parity bit is checked, not stored.
    assign shift_en = serial_valid && (cnt_q < CW'(DATA_WIDTH));
    assign gap      = (state_q == ST_SHIFT) && !serial_valid;

`ifdef DESERIALIZER_PARITY_CHECK_EN
    assign word      = shift_q;
    assign word_perr = ^{shift_q, serial_in};
`else
    assign word      = shift_d;
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_q <= shift_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (serial_valid) begin
                        if (last_bit) begin
                            cnt_q <= '0;
                        end else begin
                            cnt_q   <= CW'(1);
                            state_q <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (!serial_valid || last_bit) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
            // Set has priority over a coincident clear.
            frame_err_q <= gap  || (frame_err_q && !flags_clr);
            overrun_q   <= drop || (overrun_q   && !flags_clr);
        end
    end

    deser_hold_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clock      (clock),
        .reset      (reset),
        .load       (last_bit),
        .word       (word),
        .perr       (word_perr),
        .ready      (data_ready),
        .clr        (flags_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .drop       (drop)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - directed self-checking bench for deserializer
module tb_deserializer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_valid = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       flags_clr = 1'b0;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    deserializer #(.DATA_WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .flags_clr    (flags_clr),
        .parity_err   (parity_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            serial_valid = 1'b1;
            serial_in    = w[i];
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] w, input logic pbit);
        send_bits(w, 8);
`ifdef DESERIALIZER_PARITY_CHECK_EN
        serial_valid = 1'b1;
        serial_in    = pbit;
        tick();
`else
        if (pbit) begin
            serial_in = 1'b0;
        end
`endif
    endtask

    task automatic send_word(input logic [7:0] w);
        send_frame(w, ^w);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_data",  {24'd0, data_out}, 32'h00);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
        chk("rst_ovr",   {31'd0, overrun}, 32'd0);
        chk("rst_perr",  {31'd0, parity_err}, 32'd0);
        reset = 1'b1;
        tick();

        // single word, consumer ready
        data_ready = 1'b1;
        send_word(8'h9E);
        serial_valid = 1'b0;
        chk("t1_valid", {31'd0, data_valid}, 32'd1);
        chk("t1_data",  {24'd0, data_out}, 32'h9E);
        chk("t1_perr",  {31'd0, parity_err}, 32'd0);
        tick();
        chk("t1_valid_gone", {31'd0, data_valid}, 32'd0);
        chk("t1_ferr", {31'd0, frame_err}, 32'd0);
        chk("t1_ovr",  {31'd0, overrun}, 32'd0);

        // back-to-back frames
        data_ready = 1'b0;
        send_word(8'h9E);
        chk("t2_first_valid", {31'd0, data_valid}, 32'd1);
        chk("t2_first_data",  {24'd0, data_out}, 32'h9E);
        data_ready = 1'b1;
        send_word(8'h3C);
        serial_valid = 1'b0;
        chk("t2_second_valid", {31'd0, data_valid}, 32'd1);
        chk("t2_second_data",  {24'd0, data_out}, 32'h3C);
        chk("t2_ovr", {31'd0, overrun}, 32'd0);
        tick();
        chk("t2_drain", {31'd0, data_valid}, 32'd0);

        // overrun with consumer stalled
        data_ready = 1'b0;
        send_word(8'h9E);
        send_word(8'h3C);
        serial_valid = 1'b0;
        chk("t3_data", {24'd0, data_out}, 32'h9E);
        chk("t3_valid", {31'd0, data_valid}, 32'd1);
        chk("t3_ovr", {31'd0, overrun}, 32'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("t3_ovr_clr", {31'd0, overrun}, 32'd0);
        chk("t3_hold", {24'd0, data_out}, 32'h9E);
        data_ready = 1'b1;
        tick();
        chk("t3_drain", {31'd0, data_valid}, 32'd0);

        // frame gap then full frame
        data_ready = 1'b0;
        send_bits(8'hFF, 5);
        serial_valid = 1'b0;
        tick();
        chk("t4_ferr", {31'd0, frame_err}, 32'd1);
        chk("t4_no_partial", {31'd0, data_valid}, 32'd0);
        send_word(8'hA5);
        serial_valid = 1'b0;
        chk("t4_valid", {31'd0, data_valid}, 32'd1);
        chk("t4_data", {24'd0, data_out}, 32'hA5);
        chk("t4_ferr_sticky", {31'd0, frame_err}, 32'd1);
        data_ready = 1'b1;
        tick();
        chk("t4_drain", {31'd0, data_valid}, 32'd0);

        // async reset mid-frame
        send_bits(8'h9E, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_data", {24'd0, data_out}, 32'h00);
        chk("t5_valid", {31'd0, data_valid}, 32'd0);
        chk("t5_ferr", {31'd0, frame_err}, 32'd0);
        serial_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("t5_idle", {31'd0, data_valid}, 32'd0);
        send_word(8'h9E);
        serial_valid = 1'b0;
        chk("t5_data_after", {24'd0, data_out}, 32'h9E);
        chk("t5_valid_after", {31'd0, data_valid}, 32'd1);
        chk("t5_ferr_after", {31'd0, frame_err}, 32'd0);
        tick();

`ifdef DESERIALIZER_PARITY_CHECK_EN
        send_frame(8'h9E, 1'b1);
        serial_valid = 1'b0;
        chk("t6_good_data", {24'd0, data_out}, 32'h9E);
        chk("t6_good_perr", {31'd0, parity_err}, 32'd0);
        tick();
        send_frame(8'h9E, 1'b0);
        serial_valid = 1'b0;
        chk("t6_bad_data", {24'd0, data_out}, 32'h9E);
        chk("t6_bad_perr", {31'd0, parity_err}, 32'd1);
        flags_clr = 1'b1;
        tick();
        flags_clr = 1'b0;
        chk("t6_perr_clr", {31'd0, parity_err}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
